// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state encoding, the bubble ALUOp and the control bundle decode.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] ALUOP_NOP = 4'h0;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_LOAD_STALL = 3'd1,
        ST_FLUSH      = 3'd2,
        ST_MEM_WAIT   = 3'd3,
        ST_HALT       = 3'd4
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic halted;
    } ctrl_t;

    function automatic ctrl_t decode(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_RUN: begin
                c.pc_write     = 1'b1;
                c.if_id_write  = 1'b1;
                c.id_ex_write  = 1'b1;
                c.ex_mem_write = 1'b1;
            end
            ST_LOAD_STALL: begin
                c.id_ex_write  = 1'b1;
                c.id_ex_flush  = 1'b1;
                c.ex_mem_write = 1'b1;
            end
            ST_FLUSH: begin
                c.pc_write     = 1'b1;
                c.if_id_write  = 1'b1;
                c.if_id_flush  = 1'b1;
                c.id_ex_write  = 1'b1;
                c.id_ex_flush  = 1'b1;
                c.ex_mem_write = 1'b1;
            end
            ST_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX load.
// Register 0 is hard-wired, so a load to it never creates a dependency.
module load_use_detect #(
    parameter int AW = pipeline_ctrl_pkg::REG_ADDR_W
) (
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic          ex_memRead,
    input  logic [AW-1:0] ex_rd,
    output logic          hz
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = id_uses_rs && (id_rs == ex_rd);
        rt_match = id_uses_rt && (id_rt == ex_rd);
        hz = ex_memRead && (ex_rd != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: Moore FSM driving PC and pipeline-register controls.
// Outputs are registered from the next-state decode so they track state_q.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W        = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_memRead,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    input  logic                  ex_halt,
    input  logic                  resume,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_write,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_count
);

    import pipeline_ctrl_pkg::*;

    localparam int CW = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;

    state_e           state_q, state_d, sel;
    logic [CW-1:0]    ls_cnt_q, ls_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             hz;
    logic             reeval;
    logic             stalling;

    load_use_detect #(.AW(REG_ADDR_W)) u_lud (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_memRead (ex_memRead),
        .ex_rd      (ex_rd),
        .hz         (hz)
    );

    always_comb begin
        if (ex_halt)              sel = ST_HALT;
        else if (mem_busy)        sel = ST_MEM_WAIT;
        else if (ex_branch_taken) sel = ST_FLUSH;
        else if (hz)              sel = ST_LOAD_STALL;
        else                      sel = ST_RUN;
    end

    always_comb begin
        state_d = state_q;
        reeval  = 1'b0;
        case (state_q)
            ST_RUN:      reeval = 1'b1;
            ST_FLUSH:    reeval = 1'b1;
            ST_LOAD_STALL:
                reeval = ex_halt || mem_busy || ex_branch_taken ||
                         (ls_cnt_q == '0);
            ST_MEM_WAIT: reeval = !mem_busy;
            ST_HALT:     if (resume) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
        if (reeval) state_d = sel;
    end

    // Counter reloads whenever LOAD_STALL is (re)entered, including back-to-back.
    always_comb begin
        ls_cnt_d = ls_cnt_q;
        if (state_q == ST_LOAD_STALL && !reeval)
            ls_cnt_d = ls_cnt_q - CW'(1);
        else if (state_d == ST_LOAD_STALL)
            ls_cnt_d = CW'(LOAD_STALL_CYCLES - 1);
    end

    always_comb begin
        stalling = (state_q == ST_LOAD_STALL) ||
                   (state_q == ST_FLUSH) ||
                   (state_q == ST_MEM_WAIT);
        cnt_d = cnt_q;
        if (stalling && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
        ctrl_d = decode(state_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RUN;
            ls_cnt_q <= '0;
            cnt_q    <= '0;
            ctrl_q   <= decode(ST_RUN);
        end else begin
            state_q  <= state_d;
            ls_cnt_q <= ls_cnt_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign pc_write     = ctrl_q.pc_write;
    assign if_id_write  = ctrl_q.if_id_write;
    assign if_id_flush  = ctrl_q.if_id_flush;
    assign id_ex_write  = ctrl_q.id_ex_write;
    assign id_ex_flush  = ctrl_q.id_ex_flush;
    assign ex_mem_write = ctrl_q.ex_mem_write;
    assign halted       = ctrl_q.halted;
    assign stall_count  = cnt_q;

endmodule
